pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//  Program-counter and fetch-control stage sitting directly upstream of Instruction_Memory.
//  Holds the PC and drives it onto the memory read_address.
//  Computes next PC from sequential / branch / jump requests, honours stall and halt.
//  Flags fetched words valid to the decode stage and counts fetches.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC value loaded on reset.
//  IMEM_DEPTH  128            words in Instruction_Memory; legal PC range [0, IMEM_DEPTH*4-4].
// PORTS
//  clk              in   1   single system clock, all state on rising edge
//  rst_n            in   1   asynchronous, active-low reset
//  stall            in   1   hold PC and counter this cycle
//  halt_req         in   1   enter HALT at next edge (sticky until reset)
//  branch_taken     in   1   take PC-relative branch
//  branch_imm       in   16  MIPS I-type immediate (word offset, signed)
//  jump_en          in   1   take J-type jump
//  jump_index       in   26  MIPS J-type target index
//  instr_in         in   32  word returned by Instruction_Memory for pc
//  pc               out  32  current PC -> Instruction_Memory read_address
//  pc_plus4         out  32  pc + 4, for link / branch base
//  instr_out        out  32  instr_in forwarded to decode
//  instr_valid      out  1   instr_out is a live fetch this cycle
//  halted           out  1   fetch stopped (HALT state)
//  addr_fault       out  1   sticky: attempted next PC outside legal range
//  fetch_count      out  32  number of non-stalled RUN cycles since reset
// BEHAVIOUR
//  Reset (rst_n=0, async): pc=RESET_PC, state=BOOT, instr_valid=0, halted=0,
//   addr_fault=0, fetch_count=0. pc_plus4 = pc+4 and instr_out = instr_in are combinational always.
//  FSM: BOOT -> RUN after one clk (gives memory a settle cycle; instr_valid=0 in BOOT).
//   RUN -> HALT on halt_req, or on illegal next PC (also sets addr_fault).
//   HALT is terminal until rst_n; pc frozen, instr_valid=0, halted=1.
//  instr_valid = (state==RUN) & ~stall, combinational.
//  Next PC in RUN, not stalled, priority high->low:
//   jump_en:      {pc_plus4[31:28], jump_index, 2'b00}
//   branch_taken: pc_plus4 + {{14{branch_imm[15]}}, branch_imm, 2'b00} (mod 2^32)
//   else:         pc_plus4
//  Simultaneous jump_en & branch_taken: jump wins. halt_req beats all: PC unchanged, -> HALT.
//  stall=1 in RUN: pc, fetch_count, state held; halt_req still honoured.
//  Illegal next PC (>= IMEM_DEPTH*4, incl. wrap past 2^32): pc NOT updated, -> HALT, addr_fault=1.
//   The in-range last word is still fetched validly in that cycle.
//  fetch_count +1 each RUN cycle with stall=0; wraps mod 2^32.
//  Branch/jump inputs ignored in BOOT and HALT. rst_n mid-run restarts at BOOT immediately.
// STRUCTURE
//  Shared package mips_pkg: fetch state enum {BOOT, RUN, HALT}, WORD_W=32,
//   IMM_W=16, JIDX_W=26, PC_STEP=4.
//  One sub-module: pc_next_sel (combinational next-PC mux + range check),
//   instantiated once; FSM, PC register and counter stay in pc_fetch_unit.
// TESTING
//  Release rst_n, no requests -> pc 0 in BOOT (valid=0), then 0,4,8,...; fetch_count tracks.
//  At pc=0x10 pulse branch_taken, imm=16'hFFFE -> next pc=0x0C; imm=16'h0003 -> 0x20.
//  At pc=0x08 assert jump_en, index=26'h10 and branch_taken together -> pc=0x40 (jump wins).
//  Hold stall 3 cycles at pc=0x14 -> pc, fetch_count unchanged, instr_valid=0; then resumes 0x18.
//  Run to pc=0x1FC (IMEM_DEPTH=128) -> next edge: pc stays 0x1FC, halted=1, addr_fault=1.
//  Assert rst_n=0 asynchronously mid-RUN at pc=0x30 -> pc=0, halted=0, count=0 without a clk edge.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared fetch-stage types and widths for the MIPS-style front end.
package mips_pkg;

  localparam int WORD_W  = 32;
  localparam int IMM_W   = 16;
  localparam int JIDX_W  = 26;
  localparam int PC_STEP = 4;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC selection (jump > branch > sequential) with a legality
// check against the instruction memory window, including 32-bit wrap-around.
module pc_next_sel
  import mips_pkg::*;
#(
  parameter int IMEM_DEPTH = 128
) (
  input  logic [WORD_W-1:0] pc,
  input  logic              branch_taken,
  input  logic [IMM_W-1:0]  branch_imm,
  input  logic              jump_en,
  input  logic [JIDX_W-1:0] jump_index,
  output logic [WORD_W-1:0] pc_plus4,
  output logic [WORD_W-1:0] next_pc,
  output logic              illegal
);

  localparam logic [WORD_W:0] PC_LIMIT = (WORD_W+1)'(IMEM_DEPTH) * (WORD_W+1)'(PC_STEP);

  logic [WORD_W:0]   seq_sum;
  logic [WORD_W-1:0] branch_off;
  logic [WORD_W:0]   br_sum;
  logic              br_wrap;
  logic              wrap;

  assign seq_sum    = {1'b0, pc} + (WORD_W+1)'(PC_STEP);
  assign pc_plus4   = seq_sum[WORD_W-1:0];
  assign branch_off = {{(WORD_W-IMM_W-2){branch_imm[IMM_W-1]}}, branch_imm, 2'b00};
  assign br_sum     = {1'b0, pc_plus4} + {1'b0, branch_off};
  // Positive offset wraps on carry-out; negative offset underflows on no carry.
  assign br_wrap    = br_sum[WORD_W] ^ branch_imm[IMM_W-1];

  always_comb begin
    next_pc = pc_plus4;
    wrap    = seq_sum[WORD_W];
    if (jump_en) begin
      next_pc = {pc_plus4[WORD_W-1:WORD_W-4], jump_index, 2'b00};
      wrap    = seq_sum[WORD_W];
    end else if (branch_taken) begin
      next_pc = br_sum[WORD_W-1:0];
      wrap    = br_wrap;
    end
  end

  assign illegal = wrap | ({1'b0, next_pc} >= PC_LIMIT);

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and fetch control: BOOT settle cycle, RUN fetching, terminal
// HALT on request or out-of-range next PC; counts non-stalled RUN cycles.
module pc_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_DEPTH = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        halt_req,
  input  logic        branch_taken,
  input  logic [15:0] branch_imm,
  input  logic        jump_en,
  input  logic [25:0] jump_index,
  input  logic [31:0] instr_in,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr_out,
  output logic        instr_valid,
  output logic        halted,
  output logic        addr_fault,
  output logic [31:0] fetch_count
);

  fetch_state_t      state_reg, state_next;
  logic [WORD_W-1:0] pc_reg, pc_next;
  logic              fault_reg, fault_next;
  logic [WORD_W-1:0] count_reg, count_next;

  logic [WORD_W-1:0] sel_pc;
  logic              sel_illegal;

  pc_next_sel #(
    .IMEM_DEPTH (IMEM_DEPTH)
  ) u_next_sel (
    .pc           (pc_reg),
    .branch_taken (branch_taken),
    .branch_imm   (branch_imm),
    .jump_en      (jump_en),
    .jump_index   (jump_index),
    .pc_plus4     (pc_plus4),
    .next_pc      (sel_pc),
    .illegal      (sel_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= BOOT;
      pc_reg    <= RESET_PC;
      fault_reg <= 1'b0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      fault_reg <= fault_next;
      count_reg <= count_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    fault_next = fault_reg;
    count_next = count_reg;
    case (state_reg)
      BOOT: state_next = RUN;
      RUN: begin
        if (!stall) begin
          count_next = count_reg + 1'b1;
        end
        // halt_req wins even under stall; the PC never moves on the way out.
        if (halt_req) begin
          state_next = HALT;
        end else if (!stall) begin
          if (sel_illegal) begin
            state_next = HALT;
            fault_next = 1'b1;
          end else begin
            pc_next = sel_pc;
          end
        end
      end
      HALT:    state_next = HALT;
      default: state_next = BOOT;
    endcase
  end

  assign pc          = pc_reg;
  assign instr_out   = instr_in;
  assign instr_valid = (state_reg == RUN) && !stall;
  assign halted      = (state_reg == HALT);
  assign addr_fault  = fault_reg;
  assign fetch_count = count_reg;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: a behavioural model predicts post-edge
// state into a scoreboard queue, checked one edge later.
module tb_pc_fetch_unit;

  localparam int DEPTH = 128;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        halt_req;
  logic        branch_taken;
  logic [15:0] branch_imm;
  logic        jump_en;
  logic [25:0] jump_index;
  logic [31:0] instr_in;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic        halted;
  logic        addr_fault;
  logic [31:0] fetch_count;

  pc_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .IMEM_DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .halt_req     (halt_req),
    .branch_taken (branch_taken),
    .branch_imm   (branch_imm),
    .jump_en      (jump_en),
    .jump_index   (jump_index),
    .instr_in     (instr_in),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .instr_out    (instr_out),
    .instr_valid  (instr_valid),
    .halted       (halted),
    .addr_fault   (addr_fault),
    .fetch_count  (fetch_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        halted;
    logic        fault;
    logic [31:0] count;
  } exp_t;

  exp_t sb[$];

  int n_cmp  = 0;
  int n_fail = 0;

  // model state: 0 BOOT, 1 RUN, 2 HALT
  int          m_state;
  logic [31:0] m_pc;
  logic        m_fault;
  logic [31:0] m_count;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_pc    = 32'h0;
    m_fault = 1'b0;
    m_count = 32'h0;
  endtask

  // Drive one cycle of stimulus, check combinational outputs, predict the edge.
  task automatic step(input logic st, input logic hr, input logic br,
                      input logic [15:0] imm, input logic jmp, input logic [25:0] jidx);
    exp_t        e;
    exp_t        got;
    logic [31:0] p4;
    longint      target;
    stall        = st;
    halt_req     = hr;
    branch_taken = br;
    branch_imm   = imm;
    jump_en      = jmp;
    jump_index   = jidx;
    instr_in     = $urandom;
    #1;
    p4 = m_pc + 32'd4;
    check("instr_valid", {31'b0, instr_valid}, {31'b0, (m_state == 1) && !st});
    check("pc_plus4", pc_plus4, p4);
    check("instr_out", instr_out, instr_in);

    if (m_state == 0) begin
      m_state = 1;
    end else if (m_state == 1) begin
      if (!st) m_count = m_count + 32'd1;
      if (hr) begin
        m_state = 2;
      end else if (!st) begin
        if (jmp)     target = longint'({p4[31:28], jidx, 2'b00});
        else if (br) target = longint'(p4) + longint'($signed(imm)) * 4;
        else         target = longint'(p4);
        if (target < 0 || target >= longint'(DEPTH * 4)) begin
          m_state = 2;
          m_fault = 1'b1;
        end else begin
          m_pc = target[31:0];
        end
      end
    end
    e.pc = m_pc; e.halted = (m_state == 2); e.fault = m_fault; e.count = m_count;
    sb.push_back(e);

    @(posedge clk);
    #1;
    got = sb.pop_front();
    check("pc", pc, got.pc);
    check("halted", {31'b0, halted}, {31'b0, got.halted});
    check("addr_fault", {31'b0, addr_fault}, {31'b0, got.fault});
    check("fetch_count", fetch_count, got.count);
    $display("step st=%0b hr=%0b br=%0b imm=%h j=%0b idx=%h -> pc=%h valid_prev cnt=%0d halted=%0b fault=%0b",
             st, hr, br, imm, jmp, jidx, pc, fetch_count, halted, addr_fault);
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0);
  endtask

  // Asynchronous reset between clock edges; outputs must clear without an edge.
  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check({tag, "_pc"}, pc, m_pc);
    check({tag, "_halted"}, {31'b0, halted}, 32'h0);
    check({tag, "_fault"}, {31'b0, addr_fault}, 32'h0);
    check({tag, "_count"}, fetch_count, 32'h0);
    check({tag, "_valid"}, {31'b0, instr_valid}, 32'h0);
    $display("async reset %s: pc=%h cnt=%0d halted=%0b", tag, pc, fetch_count, halted);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; halt_req = 1'b0; branch_taken = 1'b0;
    branch_imm = 16'h0; jump_en = 1'b0; jump_index = 26'h0; instr_in = 32'h0;
    model_reset();
    #1;
    check("rst_pc", pc, 32'h0);
    check("rst_valid", {31'b0, instr_valid}, 32'h0);
    check("rst_halted", {31'b0, halted}, 32'h0);
    check("rst_fault", {31'b0, addr_fault}, 32'h0);
    check("rst_count", fetch_count, 32'h0);
    @(posedge clk); @(posedge clk);
    #1;
    rst_n = 1'b1;

    // BOOT cycle then sequential 0 -> 4 -> 8 -> C -> 10
    nop(5);
    step(1'b0, 1'b0, 1'b1, 16'hFFFE, 1'b0, 26'h0);   // 0x10 -> 0x0C
    nop(1);                                           // -> 0x10
    step(1'b0, 1'b0, 1'b1, 16'h0003, 1'b0, 26'h0);   // -> 0x20
    step(1'b0, 1'b0, 1'b1, 16'hFFF9, 1'b0, 26'h0);   // -> 0x08
    step(1'b0, 1'b0, 1'b1, 16'h0005, 1'b1, 26'h10);  // jump wins -> 0x40
    step(1'b0, 1'b0, 1'b1, 16'hFFF4, 1'b0, 26'h0);   // -> 0x14
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 16'h0007, 1'b1, 26'h33);
    nop(7);                                           // 0x18 ... 0x30
    async_reset("midrun");

    // Reach the last legal word, then step off the end.
    nop(1);
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 26'h7F);     // -> 0x1FC
    nop(1);                                           // illegal: hold, halt, fault
    step(1'b0, 1'b0, 1'b1, 16'hFFF0, 1'b1, 26'h01);  // HALT ignores requests
    async_reset("after_fault");

    // Forward branch past the window faults from pc 0.
    nop(1);
    step(1'b0, 1'b0, 1'b1, 16'h0080, 1'b0, 26'h0);   // 0x204 illegal
    async_reset("after_branch_fault");

    // Explicit halt request under stall: no fault, PC frozen.
    nop(3);
    step(1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 26'h0);
    nop(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
